// File: rtl/demux_stream_router_4ch_if.sv
// Handshake bundle between the upstream producer, the 1:4 router and the
// four downstream channel consumers.
interface demux_stream_router_4ch_if #(
  parameter int DATA_W = 8
);
  logic                  mode;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     in_data;
  logic [1:0]            in_sel;
  logic [3:0]            out_valid;
  logic [3:0]            out_ready;
  logic [4*DATA_W-1:0]   out_data;
  logic [1:0]            last_sel;
  logic [7:0]            xfer_count;

  // Producer/consumer side (testbench or surrounding fabric)
  modport master (
    output mode, in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data, last_sel, xfer_count
  );

  // Router side
  modport slave (
    input  mode, in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data, last_sel, xfer_count
  );
endinterface

// File: rtl/demux_stream_router_4ch.sv
// 1:4 stream router: one handshaked input, four one-entry holding registers.
// Channel is chosen by in_sel (addressed) or a strict round-robin pointer.

// One channel holding register. A load wins over a same-cycle drain, so the
// old word is consumed and the new one takes its place without a bubble.
module demux_stream_router_4ch_lane #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              ready,
  input  logic [DATA_W-1:0] d,
  output logic              full,
  output logic [DATA_W-1:0] data
);
  // Holding register: load, else drain (data kept), else hold
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      data <= '0;
    end else if (load) begin
      full <= 1'b1;
      data <= d;
    end else if (full && ready) begin
      full <= 1'b0;
    end
  end
endmodule

module demux_stream_router_4ch #(
  parameter int DATA_W = 8
) (
  input logic                    clk,
  input logic                    rst,
  demux_stream_router_4ch_if.slave bus
);
  localparam int NUM_LANES = 4;

  logic [1:0]                            tgt;
  logic [1:0]                            rr_ptr;
  logic [1:0]                            last_sel;
  logic [7:0]                            xfer_count;
  logic                                  accept;
  logic [NUM_LANES-1:0]                  full;
  logic [NUM_LANES-1:0]                  load;
  logic [NUM_LANES-1:0][DATA_W-1:0]      data;

  // Target is purely combinational; ready passes straight through from the
  // target's consumer so a draining channel can be refilled in the same cycle.
  assign tgt          = bus.mode ? rr_ptr : bus.in_sel;
  assign bus.in_ready = ~full[tgt] | bus.out_ready[tgt];
  assign accept       = bus.in_valid & bus.in_ready;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    // load only on accept, which already requires in_valid, so an unknown
    // in_data while idle never reaches a register
    assign load[k] = accept & (tgt == 2'(k));

    demux_stream_router_4ch_lane #(.DATA_W(DATA_W)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .load  (load[k]),
      .ready (bus.out_ready[k]),
      .d     (bus.in_data),
      .full  (full[k]),
      .data  (data[k])
    );
  end

  // Rotation pointer, last target and transfer counter; pointer only moves on
  // round-robin accepts so a mode switch resumes where it left off.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= '0;
      last_sel   <= '0;
      xfer_count <= '0;
    end else if (accept) begin
      if (bus.mode) rr_ptr <= rr_ptr + 2'd1;
      last_sel   <= tgt;
      xfer_count <= xfer_count + 8'd1;
    end
  end

  assign bus.out_valid  = full;
  assign bus.out_data   = data;
  assign bus.last_sel   = last_sel;
  assign bus.xfer_count = xfer_count;
endmodule

// File: tb/tb_demux_stream_router_4ch.sv
// Directed + randomized bench for demux_stream_router_4ch. The reference
// model keeps a capacity-1 queue per channel plus the last word written there.
module tb_demux_stream_router_4ch;
  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  demux_stream_router_4ch_if #(.DATA_W(DATA_W)) bus ();
  demux_stream_router_4ch #(.DATA_W(DATA_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  logic [7:0] q_m[4][$];
  logic [7:0] word_m[4];
  int         rr_m, last_m, cnt_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      q_m[k].delete();
      word_m[k] = 8'h00;
    end
    rr_m = 0; last_m = 0; cnt_m = 0;
  endtask

  task automatic check_outputs();
    logic [3:0]  ev;
    logic [31:0] ed;
    for (int k = 0; k < 4; k++) begin
      ev[k]        = (q_m[k].size() != 0);
      ed[k*8 +: 8] = word_m[k];
    end
    check("out_valid", 32'(bus.out_valid), 32'(ev));
    check("out_data", bus.out_data, ed);
    check("last_sel", 32'(bus.last_sel), 32'(last_m));
    check("xfer_count", 32'(bus.xfer_count), 32'(cnt_m));
  endtask

  // One clock of traffic: drive, check in_ready mid-cycle, advance the model
  // at the edge, then check registered outputs just after it.
  task automatic step(input logic m, input logic v, input logic [7:0] d,
                      input logic [1:0] s, input logic [3:0] r, output bit acc);
    int tgt;
    bit exp_rdy;
    bus.mode = m; bus.in_valid = v; bus.in_data = d; bus.in_sel = s; bus.out_ready = r;
    #2;
    tgt     = m ? rr_m : int'(s);
    exp_rdy = (q_m[tgt].size() == 0) || r[tgt];
    check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    acc = v && exp_rdy;
    @(posedge clk);
    for (int k = 0; k < 4; k++)
      if (q_m[k].size() != 0 && r[k]) void'(q_m[k].pop_front());
    if (acc) begin
      q_m[tgt].push_back(d);
      word_m[tgt] = d;
      last_m      = tgt;
      cnt_m       = (cnt_m + 1) % 256;
      if (m) rr_m = (rr_m + 1) % 4;
    end
    #1;
    check_outputs();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus.mode = 1'($urandom); bus.in_valid = 1'($urandom); bus.in_data = 8'($urandom);
      bus.in_sel = 2'($urandom); bus.out_ready = 4'($urandom);
      @(posedge clk);
    end
    #1;
    rst = 1'b0;
    model_reset();
    check_outputs();
    bus.mode = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 4'h0;
    for (int s = 0; s < 4; s++) begin
      bus.in_sel = 2'(s);
      #1;
      check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    end
  endtask

  initial begin
    bit         acc, pend;
    logic       rm;
    logic [7:0] rd;
    logic [1:0] rs;
    logic       rv;
    logic [1:0] exp_seq[6];

    rst = 1'b1;
    bus.mode = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.in_sel = '0; bus.out_ready = '0;
    @(posedge clk); #1;

    // reset with random inputs for two cycles
    do_reset(2);

    // addressed routing of A0..A3
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 8'hA0 + 8'(k), 2'(k), 4'h0, acc);
    check("addr_valid", 32'(bus.out_valid), 32'hF);
    check("addr_data", bus.out_data, 32'hA3A2A1A0);
    check("addr_last", 32'(bus.last_sel), 32'd3);
    check("addr_count", 32'(bus.xfer_count), 32'd4);

    // backpressure on channel 2, then same-cycle drain and reload
    step(1'b0, 1'b1, 8'h77, 2'd2, 4'h0, acc);
    check("bp_stall_data", 32'(bus.out_data[23:16]), 32'hA2);
    step(1'b0, 1'b1, 8'h55, 2'd2, 4'b0100, acc);
    check("bp_reload_data", 32'(bus.out_data[23:16]), 32'h55);
    check("bp_reload_valid", 32'(bus.out_valid[2]), 32'd1);

    // round-robin 1..6 with consumers always ready
    exp_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 8'(i + 1), 2'd0, 4'hF, acc);
      check("rr_last", 32'(bus.last_sel), 32'(exp_seq[i]));
    end
    step(1'b0, 1'b1, 8'h07, 2'd3, 4'hF, acc);
    check("rr_addr_detour", 32'(bus.last_sel), 32'd3);
    step(1'b1, 1'b1, 8'h08, 2'd0, 4'hF, acc);
    check("rr_resume", 32'(bus.last_sel), 32'd2);

    // strict rotation stall on channel 1
    do_reset(1);
    step(1'b0, 1'b1, 8'h11, 2'd1, 4'h0, acc);
    step(1'b1, 1'b1, 8'h22, 2'd0, 4'h0, acc);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 8'h33, 2'd0, 4'b1101, acc);
      check("stall_ready", 32'(acc), 32'd0);
    end
    step(1'b1, 1'b1, 8'h33, 2'd0, 4'hF, acc);
    check("stall_release", 32'(bus.last_sel), 32'd1);
    step(1'b1, 1'b1, 8'h44, 2'd0, 4'hF, acc);
    check("stall_next", 32'(bus.last_sel), 32'd2);

    // randomized traffic, holding data/sel/mode while stalled
    pend = 1'b0; rm = 1'b0; rd = '0; rs = '0;
    for (int i = 0; i < 400; i++) begin
      if (!pend) begin
        rm = 1'($urandom); rd = 8'($urandom); rs = 2'($urandom);
        rv = ($urandom_range(0, 3) != 0);
      end else begin
        rv = 1'b1;
      end
      step(rm, rv, rd, rs, 4'($urandom), acc);
      pend = rv && !acc;
    end

    // counter wrap then mid-operation reset
    do_reset(1);
    for (int i = 0; i < 257; i++) step(1'b1, 1'b1, 8'($urandom), 2'($urandom), 4'hF, acc);
    check("wrap_count", 32'(bus.xfer_count), 32'd1);
    step(1'b0, 1'b0, 8'h00, 2'd0, 4'hF, acc);
    step(1'b0, 1'b1, 8'hC0, 2'd0, 4'h0, acc);
    step(1'b0, 1'b1, 8'hC1, 2'd1, 4'h0, acc);
    step(1'b0, 1'b1, 8'hC3, 2'd3, 4'h0, acc);
    check("pre_rst_valid", 32'(bus.out_valid), 32'hB);
    do_reset(1);
    check("mid_rst_valid", 32'(bus.out_valid), 32'h0);
    check("mid_rst_count", 32'(bus.xfer_count), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/demux_stream_router_4ch.md
Name: demux_stream_router_4ch

Overview:
- Clocked, handshaked front-end for the team's 1:4 demultiplexer family.
- Accepts one data word per transfer on a single valid/ready input and routes it to one of four output channels.
- Channel choice is either explicit (addressed mode) or an internal round-robin pointer.
- Each channel holds its word in a one-entry holding register until the downstream consumer on that channel accepts it.

Parameters:
- DATA_W, 8, width of each data word.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- mode  input  1  0 = addressed (use in_sel); 1 = round-robin (use internal pointer)
- in_valid  input  1  upstream word present
- in_ready  output  1  router can accept in_data this cycle
- in_data  input  DATA_W  upstream word
- in_sel  input  2  target channel in addressed mode; {S1,S0} order, 2'b00 = channel 0
- out_valid  output  4  bit k = channel k holding register full
- out_ready  input  4  bit k = channel k consumer accepts this cycle
- out_data  output  4*DATA_W  channel k word at bits [k*DATA_W +: DATA_W]
- last_sel  output  2  channel of the most recent accepted transfer
- xfer_count  output  8  total accepted transfers, modulo 256

Behaviour:
- Reset (rst=1 at posedge), all registers cleared, including mid-operation:
  - full[3:0]=0, so out_valid=4'b0000.
  - All out_data words = 0.
  - rr_ptr=0, last_sel=0, xfer_count=0.
  - Held words are discarded, not delivered.
- Target selection (combinational): tgt = mode ? rr_ptr : in_sel.
- in_ready = ~full[tgt] | out_ready[tgt].
  - This is a combinational path from out_ready to in_ready (pass-through when the target drains in the same cycle).
  - in_ready depends on mode, in_sel and rr_ptr, but never on in_valid.
- accept = in_valid & in_ready.
- drain_k = full[k] & out_ready[k]. out_ready[k] with full[k]=0 has no effect.
- Channel k update at each posedge:
  - If accept and tgt==k: data_k <= in_data, full[k] <= 1. Applies even when drain_k is true in the same cycle: the old word is consumed and the new one is loaded.
  - Else if drain_k: full[k] <= 0; data_k retains its old value.
  - Else: no change.
- Latency: an accepted word appears on out_data/out_valid for its channel on the cycle after acceptance.
- Zero-bubble throughput of one word per clock is possible when the target channel's consumer keeps out_ready high.
- Ordering:
  - Words to the same channel are delivered in acceptance order.
  - There is no ordering guarantee across channels.
- Round-robin pointer:
  - In mode=1, rr_ptr increments by 1 modulo 4 on each accept (3 -> 0 wrap).
  - In mode=0 it holds its value.
  - A mode switch does not reset rr_ptr; round-robin resumes from the held value.
- Round-robin stall: if the round-robin target is full and not draining, in_ready=0 and the router waits on that channel. It does not skip to another channel (strict rotation).
- last_sel <= tgt on accept; otherwise holds.
- xfer_count increments on accept and wraps 255 -> 0.
- Upstream protocol: in_data and in_sel must be held stable while in_valid=1 and in_ready=0. The router does not check this.
- Multiple channels may drain in the same cycle, independently of each other and of acceptance.
- X on in_data when in_valid=0 must not propagate into any channel register.

Test Plan:
- Reset: assert rst for 2 cycles with arbitrary inputs -> out_valid=0000, out_data=0, last_sel=0, xfer_count=0, in_ready=1 (all empty).
- Addressed routing: mode=0, out_ready=0000; send 8'hA0..A3 with in_sel=0,1,2,3 -> out_valid=1111, channel k holds 8'hA0+k, last_sel=3, xfer_count=4.
- Backpressure: channel 2 full, out_ready[2]=0, in_sel=2, in_valid=1 -> in_ready=0 with no state change. Then raise out_ready[2] with in_data=8'h55 -> in_ready=1 that cycle; next cycle channel 2 = 8'h55, out_valid[2]=1.
- Round-robin: mode=1, out_ready=1111, 6 consecutive words 1..6 -> routed to channels 0,1,2,3,0,1; rr_ptr ends at 2. Switch to mode=0, send 1 word with in_sel=3, return to mode=1 -> next word goes to channel 2.
- Round-robin stall: mode=1, rr_ptr=1, channel 1 full with out_ready[1]=0 -> in_ready=0 for 5 cycles while other channels are empty. Then release out_ready[1] -> word accepted into channel 1, rr_ptr=2.
- Counter wrap and mid-operation reset: 257 accepted transfers -> xfer_count=1. Assert rst while out_valid=1011 -> next cycle out_valid=0000, xfer_count=0.
